mux2_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 2:1 mux datapath between two valid/ready sources.

---
 rtl/mux2_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between two valid/ready sources, output registered.
// Latency 1 cycle, 1 word/cycle; stalled output drops both readys. Packet lock: MUX2_ARB_PKT_LOCK_EN.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
`ifdef MUX2_ARB_PKT_LOCK_EN
  input  logic             i0_last,
  input  logic             i1_last,
  output logic             o_last,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic             s,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, SRC0, SRC1} state_t;

  state_t state, state_nxt;
  logic   load;
  logic   gnt_vld;
  logic   gnt;
  logic   xfer;
  logic   last;

`ifdef MUX2_ARB_PKT_LOCK_EN
  logic   locked;
  logic   lock_src;
`endif

  assign o_valid = (state != IDLE);
  assign load    = !o_valid || o_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (i0_valid && i1_valid) begin
      gnt_vld = 1'b1;
      gnt     = !last;
    end else if (i0_valid) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (i1_valid) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end
`ifdef MUX2_ARB_PKT_LOCK_EN
    // A locked owner keeps the mux even while its valid is low.
    if (locked) begin
      gnt     = lock_src;
      gnt_vld = lock_src ? i1_valid : i0_valid;
    end
`endif
  end

  // Gated by rst_n so no source sees ready while reset is held.
  assign xfer     = rst_n && load && gnt_vld;
  assign i0_ready = xfer && !gnt;
  assign i1_ready = xfer && gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = gnt ? SRC1 : SRC0;
    end else if (o_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      s      <= 1'b0;
      last   <= 1'b1;
      cnt0   <= '0;
      cnt1   <= '0;
    end else if (xfer) begin
      o_data <= gnt ? i1_data : i0_data;
      s      <= gnt;
      last   <= gnt;
      if (!gnt && (cnt0 != {CNT_W{1'b1}})) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (gnt && (cnt1 != {CNT_W{1'b1}})) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

`ifdef MUX2_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_src <= 1'b0;
      o_last   <= 1'b0;
    end else if (xfer) begin
      o_last   <= gnt ? i1_last : i0_last;
      locked   <= !(gnt ? i1_last : i0_last);
      lock_src <= gnt;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter; a second CNT_W=2 instance shares stimulus for saturation.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       i0_valid, i1_valid;
  logic [7:0] i0_data, i1_data;
  logic       i0_ready, i1_ready;
  logic       i0_last, i1_last;
  logic       o_valid, o_last;
  logic [7:0] o_data;
  logic       o_ready;
  logic       s;
  logic [7:0] cnt0, cnt1;

  logic       sat_i0_ready, sat_i1_ready, sat_o_valid, sat_s, sat_o_last;
  logic [7:0] sat_o_data;
  logic [1:0] sat_cnt0, sat_cnt1;

  int checks   = 0;
  int failures = 0;

  mux2_rr_arbiter #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
`ifdef MUX2_ARB_PKT_LOCK_EN
    .i0_last(i0_last), .i1_last(i1_last), .o_last(o_last),
`endif
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .s(s), .cnt0(cnt0), .cnt1(cnt1)
  );

  mux2_rr_arbiter #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(sat_i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(sat_i1_ready),
`ifdef MUX2_ARB_PKT_LOCK_EN
    .i0_last(i0_last), .i1_last(i1_last), .o_last(sat_o_last),
`endif
    .o_valid(sat_o_valid), .o_data(sat_o_data), .o_ready(o_ready),
    .s(sat_s), .cnt0(sat_cnt0), .cnt1(sat_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    i0_data  = 8'h00;
    i1_data  = 8'h00;
    i0_last  = 1'b1;
    i1_last  = 1'b1;
    o_ready  = 1'b0;
    repeat (2) tick();

    // Reset state, with both sources requesting: no ready may appear.
    i0_valid = 1'b1;
    i1_valid = 1'b1;
    i0_data  = 8'hA0;
    i1_data  = 8'hB0;
    o_ready  = 1'b1;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_i0_ready", 32'(i0_ready), 32'd0);
    chk("rst_i1_ready", 32'(i1_ready), 32'd0);

    // Fairness: both valid, grants alternate starting with i0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      i0_data = 8'(8'hA0 + (j + 1) / 2);
      i1_data = 8'(8'hB0 + j / 2);
      #1;
      chk("fair_i0_ready", 32'(i0_ready), 32'((j % 2) == 0));
      chk("fair_i1_ready", 32'(i1_ready), 32'((j % 2) == 1));
      tick();
      chk("fair_o_data", 32'(o_data), ((j % 2) == 0) ? 32'(8'hA0 + j / 2) : 32'(8'hB0 + j / 2));
      chk("fair_s", 32'(s), 32'(j % 2));
      chk("fair_o_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    chk("fair_cnt0", 32'(cnt0), 32'd4);
    chk("fair_cnt1", 32'(cnt1), 32'd4);
    chk("fair_sat_cnt0", 32'(sat_cnt0), 32'd3);
    chk("fair_sat_cnt1", 32'(sat_cnt1), 32'd3);

    // Backpressure: held word B3 must stay put, no grants.
    i1_data = 8'hB4;
    o_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_i0_ready", 32'(i0_ready), 32'd0);
      chk("bp_i1_ready", 32'(i1_ready), 32'd0);
      tick();
      chk("bp_o_data", 32'(o_data), 32'hB3);
      chk("bp_s", 32'(s), 32'd1);
      chk("bp_o_valid", 32'(o_valid), 32'd1);
      chk("bp_cnt0", 32'(cnt0), 32'd4);
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1;
    chk("bp_rel_i0_ready", 32'(i0_ready), 32'd1);
    chk("bp_rel_i1_ready", 32'(i1_ready), 32'd0);
    tick();
    chk("bp_rel_o_data", 32'(o_data), 32'hA4);
    chk("bp_rel_s", 32'(s), 32'd0);

    // Asynchronous reset between edges while a word is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 32'(o_valid), 32'd0);
    chk("arst_o_data", 32'(o_data), 32'd0);
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_cnt0", 32'(cnt0), 32'd0);
    chk("arst_cnt1", 32'(cnt1), 32'd0);
    chk("arst_i0_ready", 32'(i0_ready), 32'd0);
    chk("arst_i1_ready", 32'(i1_ready), 32'd0);

    // Single source: only i1, five words back to back.
    @(negedge clk);
    rst_n    = 1'b1;
    i0_valid = 1'b0;
    i1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i1_data = 8'(8'hB0 + k);
      #1;
      chk("single_i0_ready", 32'(i0_ready), 32'd0);
      chk("single_i1_ready", 32'(i1_ready), 32'd1);
      tick();
      chk("single_o_data", 32'(o_data), 32'(8'hB0 + k));
      chk("single_s", 32'(s), 32'd1);
      @(negedge clk);
    end
    chk("single_cnt1", 32'(cnt1), 32'd5);
    chk("single_cnt0", 32'(cnt0), 32'd0);
    chk("single_sat_cnt1", 32'(sat_cnt1), 32'd3);

    // Saturation: six i0 words, the 2-bit counter sticks at 3.
    i1_valid = 1'b0;
    i0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i0_data = 8'(8'hA0 + k);
      #1;
      chk("sat_i0_ready", 32'(i0_ready), 32'd1);
      tick();
      chk("sat_o_data", 32'(o_data), 32'(8'hA0 + k));
      chk("sat_cnt0", 32'(sat_cnt0), (k < 3) ? 32'(k + 1) : 32'd3);
      chk("sat_wide_cnt0", 32'(cnt0), 32'(k + 1));
      @(negedge clk);
    end
    i0_valid = 1'b0;
    tick();
    chk("drain_o_valid", 32'(o_valid), 32'd0);
    chk("drain_o_data", 32'(o_data), 32'hA5);
    chk("drain_s", 32'(s), 32'd0);

`ifdef MUX2_ARB_PKT_LOCK_EN
    // Packet lock: i0 owns the mux until its last word, even across a valid gap.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n    = 1'b1;
    i1_valid = 1'b1;
    i1_data  = 8'hB0;
    i1_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i0_valid = (c != 2) && (c != 4);
      i0_data  = (c < 2) ? 8'(8'hA0 + c) : 8'hA2;
      i0_last  = (c == 3);
      #1;
      chk("lock_i1_ready", 32'(i1_ready), 32'(c == 4));
      chk("lock_i0_ready", 32'(i0_ready), 32'((c != 2) && (c != 4)));
      tick();
      if (c == 2) begin
        chk("lock_gap_o_valid", 32'(o_valid), 32'd0);
      end else begin
        chk("lock_o_data", 32'(o_data), (c == 4) ? 32'hB0 : ((c < 2) ? 32'(8'hA0 + c) : 32'hA2));
        chk("lock_o_last", 32'(o_last), 32'((c == 3) || (c == 4)));
        chk("lock_s", 32'(s), 32'(c == 4));
      end
      @(negedge clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
